exec_stage: RTL

Single-issue execute stage sitting directly downstream of the 32x32 register file's read ports and upstream of its write port. It latches the two register operands, performs a single-cycle ALU operation or a 32-cycle iterative multiply, and drives a registered write-back (enable/address/data) into the register file. Because the register file reads combinationally and writes on the clock edge, the stage forwards its own pending write-back onto the operands. Without forwarding, a dependent instruction issued in the write-back cycle would read a stale value.

---
 rtl/exec_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/exec_stage.sv
// exec_stage: single-issue execute stage between the register file read ports
// and its write port. Performs single-cycle ALU ops or a 32-cycle shift-add
// multiply, and forwards its own pending write-back onto the source operands.
module exec_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  op,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic [31:0] imm,
   input  logic        use_imm,
   input  logic [4:0]  rd_addr,
   output logic        wb_en,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic        illegal
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 5;
   localparam int unsigned CW   = 5;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_WB   = 2'd2
   } state_t;

   state_t          state;
   logic [XLEN-1:0] mcand;
   logic [XLEN-1:0] mplier;
   logic [XLEN-1:0] acc;
   logic [CW-1:0]   cnt;
   logic [AW-1:0]   mul_rd;

   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] mul_sum;
   logic            accept;
   logic            op_illegal;

   // Operand forwarding from the pending write-back, plus handshake decode
   always_comb begin
      op_a       = rs1_data;
      op_b       = rs2_data;
      accept     = in_valid && in_ready;
      op_illegal = (op > OP_MUL);
      mul_sum    = acc + (mplier[0] ? mcand : '0);
      if (wb_en && (wb_addr == rs1_addr) && (rs1_addr != '0)) begin
         op_a = wb_data;
      end
      if (use_imm) begin
         op_b = imm;
      end else if (wb_en && (wb_addr == rs2_addr) && (rs2_addr != '0)) begin
         op_b = wb_data;
      end
   end

   // Single-cycle ALU result
   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:  alu_res = op_a + op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_SLL:  alu_res = op_a << op_b[4:0];
         OP_SRL:  alu_res = op_a >> op_b[4:0];
         OP_SRA:  alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
         OP_SLT:  alu_res = {31'd0, ($signed(op_a) < $signed(op_b))};
         OP_SLTU: alu_res = {31'd0, (op_a < op_b)};
         default: alu_res = '0;
      endcase
   end

   // Control FSM, multiply datapath and registered write-back
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         in_ready <= 1'b1;
         wb_en    <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
         illegal  <= 1'b0;
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         cnt      <= '0;
         mul_rd   <= '0;
      end else begin
         wb_en   <= 1'b0;
         illegal <= 1'b0;
         case (state)
            S_IDLE, S_WB: begin
               if (accept) begin
                  if (op_illegal) begin
                     illegal  <= 1'b1;
                     in_ready <= 1'b1;
                     state    <= S_IDLE;
                  end else if (op == OP_MUL) begin
                     mcand    <= op_a;
                     mplier   <= op_b;
                     acc      <= '0;
                     cnt      <= '0;
                     mul_rd   <= rd_addr;
                     in_ready <= 1'b0;
                     state    <= S_MUL;
                  end else begin
                     // Writes to r0 still pass through WB but never commit
                     if (rd_addr != '0) begin
                        wb_en   <= 1'b1;
                        wb_addr <= rd_addr;
                        wb_data <= alu_res;
                     end
                     in_ready <= 1'b1;
                     state    <= S_WB;
                  end
               end else begin
                  in_ready <= 1'b1;
                  state    <= S_IDLE;
               end
            end
            S_MUL: begin
               acc    <= mul_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(31)) begin
                  if (mul_rd != '0) begin
                     wb_en   <= 1'b1;
                     wb_addr <= mul_rd;
                     wb_data <= mul_sum;
                  end
                  in_ready <= 1'b1;
                  state    <= S_WB;
               end
            end
            default: begin
               in_ready <= 1'b1;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule
